// File: rtl/serial2parallel.sv
// Reassembles a framed serial stream into DATA_W-bit words behind a one-deep valid/ready holding register.
// Define S2P_ERR_CNT_EN to add err_cnt, a saturating count of framing errors and dropped words.
module serial2parallel #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              serial_start,
  input  logic              serial_in,
  input  logic              serial_end,
  output logic [DATA_W-1:0] parallel_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_err,
  output logic              overrun
`ifdef S2P_ERR_CNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] parallel_out_q, parallel_out_d;
  logic              out_valid_q, out_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              word_done;

  always_comb begin
    if (MSB_FIRST) shifted = {shreg_q[DATA_W-2:0], serial_in};
    else           shifted = {serial_in, shreg_q[DATA_W-1:1]};
  end

  // cnt_q holds the index of the bit arriving this cycle while in SHIFT.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    frame_err_d = 1'b0;
    word_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (serial_start) begin
          shreg_d = shifted;
          cnt_d   = CNT_W'(1);
          state_d = SHIFT;
        end else if (serial_end) begin
          frame_err_d = 1'b1;
        end
      end
      SHIFT: begin
        shreg_d = shifted;
        cnt_d   = cnt_q + 1'b1;
        if (serial_start) begin
          frame_err_d = 1'b1;
          cnt_d       = CNT_W'(1);
        end else if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (serial_end) word_done   = 1'b1;
          else            frame_err_d = 1'b1;
        end else if (serial_end) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
          cnt_d       = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A completing word may reuse the register in the same cycle the pending one is taken.
  always_comb begin
    parallel_out_d = parallel_out_q;
    out_valid_d    = out_valid_q;
    overrun_d      = overrun_q;
    if (word_done) begin
      if (!out_valid_q || out_ready) begin
        parallel_out_d = shifted;
        out_valid_d    = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      shreg_q        <= '0;
      parallel_out_q <= '0;
      out_valid_q    <= 1'b0;
      frame_err_q    <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shreg_q        <= shreg_d;
      parallel_out_q <= parallel_out_d;
      out_valid_q    <= out_valid_d;
      frame_err_q    <= frame_err_d;
      overrun_q      <= overrun_d;
    end
  end

  assign parallel_out = parallel_out_q;
  assign out_valid    = out_valid_q;
  assign frame_err    = frame_err_q;
  assign overrun      = overrun_q;

`ifdef S2P_ERR_CNT_EN
  logic       word_drop;
  logic [7:0] err_cnt_q, err_cnt_d;

  assign word_drop = word_done && out_valid_q && !out_ready;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((frame_err_d || word_drop) && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= 8'h00;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: doc/serial2parallel.md
Name: serial2parallel

Overview:
- Receive-side counterpart of the team's parallel-to-serial transmitter.
- Samples a framed serial stream (serial_start / serial_in / serial_end) one bit per clock and reassembles DATA_W-bit words.
- Completed words are presented on a valid/ready output holding register.
- Flags framing errors (early end, missing end, restart mid-frame) and overruns.

Parameters:
- DATA_W, 8, word width in bits; legal range is 2 or more.
- MSB_FIRST, 1, 1 = first received bit lands in parallel_out[DATA_W-1]; 0 = first bit lands in parallel_out[0].

Ports:
- clk  input  1  single system clock; all sampling on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- serial_start  input  1  high for exactly the cycle carrying bit 0 of a frame.
- serial_in  input  1  serial data bit, valid every cycle of a frame.
- serial_end  input  1  high for exactly the cycle carrying bit DATA_W-1.
- parallel_out  output  DATA_W  assembled word; stable while out_valid=1.
- out_valid  output  1  word available in holding register.
- out_ready  input  1  consumer accepts word when out_valid && out_ready.
- frame_err  output  1  one-cycle pulse on any framing violation.
- overrun  output  1  sticky; set when a good frame is dropped; cleared only by reset.

Behaviour:
- Reset (async assert, sync release) gives these values:
  - state = IDLE, bit counter = 0, shift register = 0.
  - parallel_out = 0, out_valid = 0, frame_err = 0, overrun = 0.
  - Reset mid-frame discards the partial word silently; no frame_err is raised.
- FSM has two states, IDLE and SHIFT.
  - IDLE:
    - serial_start=1: shift in serial_in as bit 0, counter <= 1, go to SHIFT.
    - serial_end=1 without serial_start: frame_err pulse, stay in IDLE.
  - SHIFT, each cycle: shift in serial_in, then counter++.
    - serial_start=1 in SHIFT: frame_err pulse for the aborted frame. The current bit is bit 0 of a new frame; counter <= 1, stay in SHIFT.
    - serial_end=1 with counter < DATA_W-1 (early end): frame_err pulse, word discarded, go to IDLE.
    - counter == DATA_W-1 (last bit) with serial_end=1: word complete, go to IDLE.
    - counter == DATA_W-1 with serial_end=0 (missing end): frame_err pulse, word discarded, go to IDLE.
- Bit placement:
  - MSB_FIRST=1: shift left, new bit into the LSB.
  - MSB_FIRST=0: shift right, new bit into the MSB.
- Latency: out_valid rises on the clock edge after the last-bit cycle is sampled, i.e. one cycle after the serial_end cycle. parallel_out is loaded on the same edge.
- Output handshake (one-deep holding register):
  - out_valid stays high until out_valid && out_ready; it clears on the following edge.
  - Word completes while out_valid=1 and out_ready=0: new word dropped, holding register unchanged, overrun <= 1.
  - Word completes in the same cycle the pending word is accepted (out_ready=1): new word loads, out_valid stays 1, no overrun.
  - out_ready is ignored while out_valid=0.
- frame_err is registered: it pulses one cycle after the offending input cycle and lasts exactly 1 cycle.
- Back-to-back frames, with serial_start the cycle after serial_end, are accepted with no idle gap.

Optional Feature:
- Macro: S2P_ERR_CNT_EN.
- When defined:
  - Adds output err_cnt [7:0], reset 0.
  - Increments on every frame_err pulse and every dropped-word overrun event.
  - Saturates at 8'hFF and never wraps.
  - Cleared only by reset.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Nominal frame: DATA_W=8, MSB_FIRST=1, out_ready=1. Drive 8'b11010011 MSB first, with serial_start on cycle 0 and serial_end on cycle 7 -> on cycle 8: out_valid=1, parallel_out=8'hD3, frame_err=0.
- Back-to-back with stall: frames 8'hD3 then 8'h5A, out_ready=0 throughout -> parallel_out holds 8'hD3, out_valid stays 1, overrun=1 one cycle after the second serial_end. Raising out_ready then clears out_valid next cycle.
- Simultaneous accept/complete: out_ready=1 on the cycle the second word completes -> parallel_out=8'h5A, out_valid stays 1, overrun=0.
- Early end: serial_end on bit 4 -> frame_err pulses once, out_valid stays 0, FSM back in IDLE. A following good 8'hD3 frame is received correctly.
- Restart mid-frame: serial_start re-asserted at bit 3, then a full 8'hA5 frame follows -> one frame_err pulse, then out_valid with parallel_out=8'hA5. Repeat with MSB_FIRST=0, sending LSB first, -> 8'hA5.
- Reset mid-frame: rst_n low at bit 5 of a frame -> all outputs 0 immediately, no frame_err. With S2P_ERR_CNT_EN, err_cnt=0 after reset, and 3 errors then give err_cnt=3.
